// File: rtl/ps2_keyboard_if.sv
// rtl/ps2_keyboard_if.sv - PS/2 line inputs and received scan-code byte bundle
interface ps2_keyboard_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       read_complete;

  // keyboard/stimulus side drives the lines and observes the byte
  modport master (
    output ps2_clk,
    output ps2_data,
    input  data,
    input  read_complete
  );

  // receiver side samples the lines and produces the byte
  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output data,
    output read_complete
  );
endinterface

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 device-to-host frame receiver; optional PS2_PARITY_CHECK_EN enables odd-parity rejection
module ps2_keyboard #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_keyboard_if.slave bus
);

  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]  FILT_MAX = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic              clk_sync1, clk_sync2;
  logic              data_sync1, data_sync2;
  logic [FILTER_LEN:0] data_dly;
  logic              sample_bit;

  logic              filt_clk;
  logic [3:0]        filt_cnt;
  logic              fall_q;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [10:0]       frame_sr;
  logic [10:0]       frame_next;
  logic [TW-1:0]     to_cnt;
  logic              done_q;
  logic [10:0]       done_frame;

  logic              frame_ok;
  logic              chk_valid;
  logic [7:0]        chk_byte;

  // Two-flop synchronizers for both raw lines; idle level is high
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync1  <= 1'b1;
      clk_sync2  <= 1'b1;
      data_sync1 <= 1'b1;
      data_sync2 <= 1'b1;
    end else begin
      clk_sync1  <= bus.ps2_clk;
      clk_sync2  <= clk_sync1;
      data_sync1 <= bus.ps2_data;
      data_sync2 <= data_sync1;
    end
  end

  // Delay data so the bit sampled on a fall strobe is the value seen just before the raw clock fell
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_dly <= '1;
    end else begin
      data_dly <= {data_dly[FILTER_LEN-1:0], data_sync2};
    end
  end

  assign sample_bit = data_dly[FILTER_LEN];

  // Glitch filter: follow the synchronized clock only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= 4'd0;
      fall_q   <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_sync2 != filt_clk) begin
        if (filt_cnt == FILT_MAX) begin
          filt_clk <= clk_sync2;
          filt_cnt <= 4'd0;
          fall_q   <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= 4'd0;
      end
    end
  end

  // Bits arrive LSB first, so shift right: after 11 bits the start bit lands in bit 0
  assign frame_next = {sample_bit, frame_sr[10:1]};

  // Frame FSM: wait for a start bit, collect 11 bits, abandon the frame on a stalled clock
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      frame_sr   <= 11'd0;
      to_cnt     <= '0;
      done_q     <= 1'b0;
      done_frame <= 11'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt  <= '0;
          bit_cnt <= 4'd0;
          if (fall_q && !sample_bit) begin
            state    <= RECV;
            bit_cnt  <= 4'd1;
            frame_sr <= 11'd0;
          end
        end
        RECV: begin
          if (fall_q) begin
            to_cnt   <= '0;
            frame_sr <= frame_next;
            if (bit_cnt == 4'd10) begin
              state      <= IDLE;
              bit_cnt    <= 4'd0;
              done_q     <= 1'b1;
              done_frame <= frame_next;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (to_cnt == TO_MAX) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            to_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
          to_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = done_frame[10] & ~done_frame[0] & (^done_frame[9:1]);
`else
  logic parity_unused;
  assign parity_unused = done_frame[9];
  assign frame_ok      = done_frame[10] & ~done_frame[0];
`endif

  // Check stage: register the accept decision and the payload of a completed frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_valid <= 1'b0;
      chk_byte  <= 8'h00;
    end else begin
      chk_valid <= done_q & frame_ok;
      chk_byte  <= done_frame[8:1];
    end
  end

  // Output stage: update the held byte and pulse read_complete together
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.data          <= 8'h00;
      bus.read_complete <= 1'b0;
    end else begin
      bus.read_complete <= chk_valid;
      if (chk_valid) begin
        bus.data <= chk_byte;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - directed self-checking bench for ps2_keyboard
`timescale 1ns/1ps
module tb_ps2_keyboard;

  localparam int FLEN = 4;
  localparam int TOUT = 400;
  localparam int HALF = 40;

  logic clk;
  logic rst;
  ps2_keyboard_if bus();

  ps2_keyboard #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int double_cnt = 0;
  logic prev_rc = 1'b0;
  logic [7:0] pulse_data [$];

  always @(negedge clk) begin
    if (bus.read_complete === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_data.push_back(bus.data);
      if (prev_rc === 1'b1) double_cnt = double_cnt + 1;
    end
    prev_rc = bus.read_complete;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    bus.ps2_data = b;
    if (glitch) begin
      wait_cycles(HALF / 2);
      bus.ps2_clk = 1'b0;
      wait_cycles(2);
      bus.ps2_clk = 1'b1;
      wait_cycles(HALF / 2 - 2);
    end else begin
      wait_cycles(HALF);
    end
    bus.ps2_clk = 1'b0;
    wait_cycles(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit, output int lat);
    logic [10:0] bits;
    logic par;
    par  = ~^b;
    if (bad_par) par = ~par;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i], i == glitch_bit);
    bus.ps2_data = 1'b1;
    wait_cycles(HALF);
    bus.ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= HALF; k++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && bus.read_complete === 1'b1) lat = k;
    end
    @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", bus.data); end
    n_cmp++;
    if (bus.read_complete !== 1'b0) begin n_bad++; $display("FAIL reset_rc got=%b exp=0", bus.read_complete); end
  endtask

  task automatic test_single();
    int base, lat;
    base = pulse_cnt;
    send_frame(8'h1C, 1'b0, -1, lat);
    wait_cycles(20);
    n_cmp++;
    if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", pulse_cnt - base); end
    n_cmp++;
    if (pulse_cnt > base && pulse_data[base] !== 8'h1C) begin n_bad++; $display("FAIL single_data got=%h exp=1c", pulse_data[base]); end
    else if (pulse_cnt <= base) begin n_bad++; $display("FAIL single_data got=none exp=1c"); end
    n_cmp++;
    if (lat !== FLEN + 5) begin n_bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, FLEN + 5); end
    wait_cycles(100);
    n_cmp++;
    if (bus.data !== 8'h1C) begin n_bad++; $display("FAIL single_hold got=%h exp=1c", bus.data); end
  endtask

  task automatic test_back_to_back();
    int base, lat;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hE0; exp_q[1] = 8'hF0; exp_q[2] = 8'h75;
    base = pulse_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b0, -1, lat);
    wait_cycles(20);
    n_cmp++;
    if (pulse_cnt - base !== 3) begin n_bad++; $display("FAIL b2b_count got=%0d exp=3", pulse_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (base + i >= pulse_cnt) begin n_bad++; $display("FAIL b2b_data%0d got=none exp=%h", i, exp_q[i]); end
      else if (pulse_data[base + i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, pulse_data[base + i], exp_q[i]); end
    end
    n_cmp++;
    if (double_cnt !== 0) begin n_bad++; $display("FAIL b2b_single_cycle got=%0d exp=0 wide pulses", double_cnt); end
  endtask

  task automatic test_parity();
    int base, lat;
    base = pulse_cnt;
    send_frame(8'h1C, 1'b1, -1, lat);
    wait_cycles(20);
`ifdef PS2_PARITY_CHECK_EN
    n_cmp++;
    if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL parity_count got=%0d exp=0", pulse_cnt - base); end
    n_cmp++;
    if (bus.data !== 8'h75) begin n_bad++; $display("FAIL parity_data got=%h exp=75", bus.data); end
`else
    n_cmp++;
    if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL parity_count got=%0d exp=1", pulse_cnt - base); end
    n_cmp++;
    if (bus.data !== 8'h1C) begin n_bad++; $display("FAIL parity_data got=%h exp=1c", bus.data); end
`endif
  endtask

  task automatic test_timeout();
    int base, lat;
    logic [7:0] part;
    part = 8'hA5;
    base = pulse_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i], 1'b0);
    bus.ps2_data = 1'b1;
    wait_cycles(TOUT + 100);
    send_frame(8'h29, 1'b0, -1, lat);
    wait_cycles(20);
    n_cmp++;
    if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL timeout_count got=%0d exp=1", pulse_cnt - base); end
    n_cmp++;
    if (bus.data !== 8'h29) begin n_bad++; $display("FAIL timeout_data got=%h exp=29", bus.data); end
  endtask

  task automatic test_glitch();
    int base, lat;
    base = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.ps2_clk = 1'b0;
      wait_cycles(2);
      bus.ps2_clk = 1'b1;
      wait_cycles(30);
    end
    n_cmp++;
    if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL glitch_idle_count got=%0d exp=0", pulse_cnt - base); end
    send_frame(8'h5A, 1'b0, 3, lat);
    wait_cycles(20);
    n_cmp++;
    if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL glitch_count got=%0d exp=1", pulse_cnt - base); end
    n_cmp++;
    if (bus.data !== 8'h5A) begin n_bad++; $display("FAIL glitch_data got=%h exp=5a", bus.data); end
  endtask

  task automatic test_mid_reset();
    int base, lat;
    logic [10:0] bits;
    bits = {1'b1, ~^8'h12, 8'h12, 1'b0};
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) send_bit(bits[i], 1'b0);
    bus.ps2_data = bits[5];
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(1);
    rst = 1'b1;
    n_cmp++;
    if (bus.data !== 8'h00) begin n_bad++; $display("FAIL midrst_data got=%h exp=00", bus.data); end
    n_cmp++;
    if (bus.read_complete !== 1'b0) begin n_bad++; $display("FAIL midrst_rc got=%b exp=0", bus.read_complete); end
    wait_cycles(HALF - 6);
    bus.ps2_clk = 1'b0;
    wait_cycles(HALF);
    bus.ps2_clk = 1'b1;
    for (int i = 6; i < 11; i++) send_bit(bits[i], 1'b0);
    bus.ps2_data = 1'b1;
    wait_cycles(TOUT + 100);
    n_cmp++;
    if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL midrst_nopulse got=%0d exp=0", pulse_cnt - base); end
    n_cmp++;
    if (bus.data !== 8'h00) begin n_bad++; $display("FAIL midrst_hold got=%h exp=00", bus.data); end
    send_frame(8'h12, 1'b0, -1, lat);
    wait_cycles(20);
    n_cmp++;
    if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL after_rst_count got=%0d exp=1", pulse_cnt - base); end
    n_cmp++;
    if (bus.data !== 8'h12) begin n_bad++; $display("FAIL after_rst_data got=%h exp=12", bus.data); end
  endtask

  initial begin
    rst = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cycles(4);
    test_reset();
    rst = 1'b1;
    wait_cycles(10);
    test_single();
    test_back_to_back();
    test_parity();
    test_timeout();
    test_glitch();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
